// File: rtl/led_walk_pkg.sv
// led_walk_pkg: shared symbol codes, mode/state encodings and a symbol validity helper
// for the LED walk decoder.
`default_nettype none

package led_walk_pkg;

   localparam logic [2:0] SYM_A = 3'b001;
   localparam logic [2:0] SYM_B = 3'b100;
   localparam logic [2:0] SYM_C = 3'b101;
   localparam logic [2:0] SYM_D = 3'b010;

   typedef enum logic [1:0] {
      MODE_NONE = 2'b00,
      MODE_SW0  = 2'b01,
      MODE_SW1  = 2'b10
   } mode_t;

   typedef enum logic [1:0] {
      HUNT   = 2'b00,
      TRACK  = 2'b01,
      LOCKED = 2'b10
   } state_t;

   function automatic logic is_valid_sym(input logic [2:0] s);
      return (s == SYM_A) || (s == SYM_B) || (s == SYM_C) || (s == SYM_D);
   endfunction

endpackage : led_walk_pkg

`default_nettype wire

// File: rtl/led_walk_pair_class.sv
// led_walk_pair_class: classifies a (prev, cur) symbol pair into the walk mode that
// produces it, or flags it illegal. Purely combinational.
`default_nettype none

module led_walk_pair_class
   import led_walk_pkg::*;
(
   input  logic [2:0] prev,
   input  logic [2:0] cur,
   output logic       cur_valid,
   output logic       pair_legal,
   output mode_t      pair_mode
);

   always_comb begin
      cur_valid  = is_valid_sym(cur);
      pair_legal = 1'b1;
      pair_mode  = MODE_NONE;
      case ({prev, cur})
         {SYM_A, SYM_B}, {SYM_B, SYM_A},
         {SYM_C, SYM_A}, {SYM_D, SYM_A}: pair_mode = MODE_NONE;
         {SYM_A, SYM_C}, {SYM_C, SYM_B},
         {SYM_B, SYM_D}, {SYM_D, SYM_C}: pair_mode = MODE_SW0;
         {SYM_A, SYM_D}, {SYM_D, SYM_B},
         {SYM_B, SYM_C}, {SYM_C, SYM_D}: pair_mode = MODE_SW1;
         default:                        pair_legal = 1'b0;
      endcase
   end

endmodule : led_walk_pair_class

`default_nettype wire

// File: rtl/led_walk_decoder.sv
// led_walk_decoder: recovers the switch mode driving an LED walk from its symbol stream,
// with lock detection, an error pulse and a saturating error counter.
`default_nettype none

module led_walk_decoder
   import led_walk_pkg::*;
#(
   parameter int LOCK_COUNT = 3,
   parameter int ERR_W      = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sym_valid,
   input  logic [2:0]       sym,
   output logic [1:0]       mode,
   output logic             mode_valid,
   output logic             err,
   output logic [ERR_W-1:0] err_count
);

   localparam int                CNT_W    = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0]  LOCK_CNT = CNT_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   state_t           state;
   mode_t            cand;
   logic [2:0]       prev;
   logic [CNT_W-1:0] match_cnt;
   logic [CNT_W-1:0] track_cnt;
   logic [ERR_W-1:0] err_count_inc;
   logic             cur_valid;
   logic             pair_legal;
   mode_t            pair_mode;

   led_walk_pair_class u_pair_class (
      .prev       (prev),
      .cur        (sym),
      .cur_valid  (cur_valid),
      .pair_legal (pair_legal),
      .pair_mode  (pair_mode)
   );

   // A mode change restarts the streak at 1: the changing pair itself already counts.
   always_comb begin
      track_cnt     = ((match_cnt == '0) || (pair_mode == cand)) ? match_cnt + 1'b1 : CNT_ONE;
      err_count_inc = (&err_count) ? err_count : err_count + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= HUNT;
         cand       <= MODE_NONE;
         prev       <= '0;
         match_cnt  <= '0;
         mode       <= 2'b00;
         mode_valid <= 1'b0;
         err        <= 1'b0;
         err_count  <= '0;
      end else begin
         err <= 1'b0;
         if (sym_valid) begin
            if (!cur_valid) begin
               // Garbage symbol: drop lock but keep the last mode on display.
               err        <= 1'b1;
               err_count  <= err_count_inc;
               state      <= HUNT;
               mode_valid <= 1'b0;
               match_cnt  <= '0;
            end else begin
               prev <= sym;
               case (state)
                  HUNT: begin
                     state     <= TRACK;
                     match_cnt <= '0;
                  end
                  TRACK: begin
                     if (!pair_legal) begin
                        err       <= 1'b1;
                        err_count <= err_count_inc;
                        match_cnt <= '0;
                     end else begin
                        cand      <= pair_mode;
                        match_cnt <= track_cnt;
                        if (track_cnt == LOCK_CNT) begin
                           state      <= LOCKED;
                           mode       <= pair_mode;
                           mode_valid <= 1'b1;
                        end
                     end
                  end
                  LOCKED: begin
                     if (!pair_legal) begin
                        err        <= 1'b1;
                        err_count  <= err_count_inc;
                        state      <= TRACK;
                        mode_valid <= 1'b0;
                        match_cnt  <= '0;
                     end else if (pair_mode != cand) begin
                        state      <= TRACK;
                        mode_valid <= 1'b0;
                        cand       <= pair_mode;
                        match_cnt  <= CNT_ONE;
                     end
                  end
                  default: state <= HUNT;
               endcase
            end
         end
      end
   end

endmodule : led_walk_decoder

`default_nettype wire

// File: tb/tb_led_walk_decoder.sv
// tb_led_walk_decoder: directed and randomized stimulus checked against a
// table-driven behavioural model of the walk decoder.
`default_nettype none

module tb_led_walk_decoder;

   localparam int LOCK_COUNT = 3;
   localparam int ERR_W      = 8;
   localparam int ERR_MAX    = (1 << ERR_W) - 1;

   localparam logic [2:0] A = 3'b001;
   localparam logic [2:0] B = 3'b100;
   localparam logic [2:0] C = 3'b101;
   localparam logic [2:0] D = 3'b010;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             sym_valid;
   logic [2:0]       sym;
   logic [1:0]       mode;
   logic             mode_valid;
   logic             err;
   logic [ERR_W-1:0] err_count;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   // Legal pair table: entries 0-3 mode 00, 4-7 mode 01, 8-11 mode 10.
   logic [2:0] tp [12] = '{A, B, C, D,  A, C, B, D,  A, D, B, C};
   logic [2:0] tc [12] = '{B, A, A, A,  C, B, D, C,  D, B, C, D};
   logic [2:0] bad_syms [4] = '{3'b000, 3'b011, 3'b110, 3'b111};

   // Reference model state
   bit         m_hunt;
   logic [2:0] m_prev;
   int         m_streak;
   int         m_cand;
   int         m_mode;
   bit         m_locked;
   bit         m_err;
   int         m_cnt;

   led_walk_decoder #(.LOCK_COUNT(LOCK_COUNT), .ERR_W(ERR_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sym_valid  (sym_valid),
      .sym        (sym),
      .mode       (mode),
      .mode_valid (mode_valid),
      .err        (err),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   function automatic int legal_mode(input logic [2:0] p, input logic [2:0] c);
      for (int i = 0; i < 12; i++)
         if (tp[i] == p && tc[i] == c) return i / 4;
      return -1;
   endfunction

   function automatic logic [2:0] next_sym(input logic [2:0] p, input int md);
      for (int i = md * 4; i < md * 4 + 4; i++)
         if (tp[i] == p) return tc[i];
      return A;
   endfunction

   task automatic model_reset();
      m_hunt = 1; m_prev = '0; m_streak = 0; m_cand = 0;
      m_mode = 0; m_locked = 0; m_err = 0; m_cnt = 0;
   endtask

   task automatic model_err();
      m_err = 1;
      m_cnt = (m_cnt < ERR_MAX) ? m_cnt + 1 : ERR_MAX;
   endtask

   task automatic model_step(input logic [2:0] s);
      int md;
      m_err = 0;
      if (!(s inside {A, B, C, D})) begin
         model_err();
         m_hunt = 1; m_locked = 0; m_streak = 0;
      end else if (m_hunt) begin
         m_prev = s; m_hunt = 0; m_streak = 0;
      end else begin
         md = legal_mode(m_prev, s);
         m_prev = s;
         if (md < 0) begin
            model_err();
            m_streak = 0; m_locked = 0;
         end else if (m_locked) begin
            if (md != m_mode) begin
               m_locked = 0; m_cand = md; m_streak = 1;
            end
         end else begin
            m_streak = (m_streak == 0 || md == m_cand) ? m_streak + 1 : 1;
            m_cand = md;
            if (m_streak == LOCK_COUNT) begin
               m_locked = 1; m_mode = m_cand;
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".mode"},       32'(mode),       32'(m_mode));
      check({tag, ".mode_valid"}, 32'(mode_valid), 32'(m_locked));
      check({tag, ".err"},        32'(err),        32'(m_err));
      check({tag, ".err_count"},  32'(err_count),  32'(m_cnt));
   endtask

   // Called at a negedge; presents the symbol, samples results at the next negedge.
   task automatic send(input logic [2:0] s, input string tag);
      sym_valid = 1'b1;
      sym       = s;
      @(negedge clk);
      model_step(s);
      check_all(tag);
   endtask

   task automatic idle(input int n, input string tag);
      sym_valid = 1'b0;
      sym       = $urandom_range(0, 7);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         m_err = 0;
         check_all(tag);
      end
   endtask

   task automatic do_reset();
      sym_valid = 1'b0;
      reset_n   = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   initial begin
      int run_mode;
      int r;
      logic [2:0] s;
      sym_valid = 1'b0;
      sym       = '0;
      reset_n   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst.mode", 32'(mode), 0);
      check("rst.mode_valid", 32'(mode_valid), 0);
      check("rst.err", 32'(err), 0);
      check("rst.err_count", 32'(err_count), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // A,B,A,B with 5-cycle gaps: lock on the 4th symbol, mode 00
      send(A, "p1.s1"); idle(5, "p1.gap");
      send(B, "p1.s2"); idle(5, "p1.gap");
      send(A, "p1.s3"); idle(5, "p1.gap");
      check("p1.prelock", 32'(mode_valid), 0);
      send(B, "p1.s4");
      check("p1.lock", 32'(mode_valid), 1);
      check("p1.mode", 32'(mode), 0);
      idle(5, "p1.gap");

      // A,C,B,D,C back-to-back: lock at mode 01 on D, C holds
      send(A, "p2.s1"); send(C, "p2.s2"); send(B, "p2.s3");
      send(D, "p2.s4");
      check("p2.lock", 32'(mode_valid), 1);
      check("p2.mode", 32'(mode), 1);
      send(C, "p2.s5");
      check("p2.hold", 32'(mode_valid), 1);

      // Invalid symbol while locked, then relock at mode 10
      send(3'b111, "p3.bad");
      check("p3.err", 32'(err), 1);
      check("p3.mode_keep", 32'(mode), 1);
      idle(1, "p3.errdrop");
      check("p3.err_1cyc", 32'(err), 0);
      send(A, "p3.s1"); send(D, "p3.s2"); send(B, "p3.s3"); send(C, "p3.s4");
      check("p3.relock", 32'(mode), 2);

      // Lock at 00, then AD drops lock without error and D,B,C relock at 10
      send(A, "p4.s1"); send(B, "p4.s2"); send(A, "p4.s3");
      check("p4.lock00", 32'(mode_valid), 1);
      send(D, "p4.s4");
      check("p4.drop", 32'(mode_valid), 0);
      check("p4.noerr", 32'(err), 0);
      send(B, "p4.s5"); send(C, "p4.s6");
      check("p4.relock", 32'(mode), 2);
      check("p4.cnt", 32'(err_count), 1);

      // A,A,B,A,B from reset: one error on AA, lock on the 5th symbol
      do_reset();
      send(A, "p5.s1"); send(A, "p5.s2");
      check("p5.err", 32'(err), 1);
      send(B, "p5.s3"); send(A, "p5.s4"); send(B, "p5.s5");
      check("p5.lock", 32'(mode_valid), 1);
      check("p5.cnt", 32'(err_count), 1);
      idle(2, "p5.gap");

      // Randomized walks with mode switches, stray symbols and gaps
      run_mode = $urandom_range(0, 2);
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 6)       s = bad_syms[$urandom_range(0, 3)];
         else if (r < 22) s = tp[$urandom_range(0, 11)];
         else begin
            if ($urandom_range(0, 9) == 0) run_mode = $urandom_range(0, 2);
            s = next_sym(m_prev, run_mode);
         end
         send(s, "rnd");
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), "rnd.gap");
      end

      // 300 invalid symbols: counter saturates
      do_reset();
      for (int i = 0; i < 300; i++) send(bad_syms[i % 4], "sat");
      check("sat.final", 32'(err_count), ERR_MAX);

      // Asynchronous reset between clock edges
      sym_valid = 1'b1;
      sym       = 3'b111;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check("arst.mode", 32'(mode), 0);
      check("arst.mode_valid", 32'(mode_valid), 0);
      check("arst.err", 32'(err), 0);
      check("arst.err_count", 32'(err_count), 0);
      @(negedge clk);
      sym_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      idle(2, "post");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_led_walk_decoder

`default_nettype wire
